// File: rtl/serial_rx_store.sv
// 8N1 serial receiver that appends each good character to the message RAM
// as {1'b1, 7'b0, char} and always follows it with a 16'h0000 terminator word.
module serial_rx_store #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CW           = 14
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        serialIn,
  input  logic        clear,
  output logic        ram_write,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_data,
  output logic        char_valid,
  output logic [7:0]  char_out,
  output logic        frame_err,
  output logic        overflow,
  output logic        full,
  output logic [7:0]  count
);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, STORE, TERM, BREAK, CLR
  } state_t;

  state_t        state_reg, state_next;
  logic          rx_meta_reg, rx_s_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    ptr_reg, ptr_next;
  logic          ram_write_reg, ram_write_next;
  logic [7:0]    ram_addr_reg, ram_addr_next;
  logic [15:0]   ram_data_reg, ram_data_next;
  logic          char_valid_reg, char_valid_next;
  logic [7:0]    char_out_reg, char_out_next;
  logic          frame_err_reg, frame_err_next;
  logic          overflow_reg, overflow_next;
  logic          full_w;

  assign full_w = (ptr_reg == 8'hFF);

  // Two-flop synchronizer; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= serialIn;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      ptr_reg        <= '0;
      ram_write_reg  <= 1'b0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      char_valid_reg <= 1'b0;
      char_out_reg   <= '0;
      frame_err_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      ptr_reg        <= ptr_next;
      ram_write_reg  <= ram_write_next;
      ram_addr_reg   <= ram_addr_next;
      ram_data_reg   <= ram_data_next;
      char_valid_reg <= char_valid_next;
      char_out_reg   <= char_out_next;
      frame_err_reg  <= frame_err_next;
      overflow_reg   <= overflow_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    ptr_next        = ptr_reg;
    overflow_next   = overflow_reg;
    char_out_next   = char_out_reg;
    char_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    ram_write_next  = 1'b0;
    ram_addr_next   = ptr_reg;
    ram_data_next   = ram_data_reg;

    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s_reg, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (!rx_s_reg) begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end else if (full_w) begin
            overflow_next = 1'b1;
            state_next    = IDLE;
          end else begin
            char_out_next   = shift_reg;
            char_valid_next = 1'b1;
            state_next      = STORE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STORE: begin
        ptr_next   = ptr_reg + 8'd1;
        state_next = TERM;
      end
      TERM: begin
        state_next = IDLE;
      end
      BREAK: begin
        if (rx_s_reg) begin
          state_next = IDLE;
        end
      end
      CLR: begin
        ptr_next      = '0;
        overflow_next = 1'b0;
        state_next    = BREAK;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // clear wins over everything, including a stop-bit sample in the same cycle
    if (clear && (state_reg != CLR)) begin
      state_next      = CLR;
      cnt_next        = '0;
      ptr_next        = ptr_reg;
      overflow_next   = overflow_reg;
      char_out_next   = char_out_reg;
      char_valid_next = 1'b0;
      frame_err_next  = 1'b0;
    end

    // RAM port is registered: drive it from the state being entered
    ram_addr_next = ptr_next;
    case (state_next)
      STORE: begin
        ram_write_next = 1'b1;
        ram_addr_next  = ptr_reg;
        ram_data_next  = {1'b1, 7'b0, shift_reg};
      end
      TERM: begin
        ram_write_next = 1'b1;
        ram_addr_next  = ptr_next;
        ram_data_next  = 16'h0000;
      end
      CLR: begin
        ram_write_next = 1'b1;
        ram_addr_next  = 8'd0;
        ram_data_next  = 16'h0000;
      end
      default: begin
        ram_write_next = 1'b0;
      end
    endcase
  end

  assign ram_write  = ram_write_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_data   = ram_data_reg;
  assign char_valid = char_valid_reg;
  assign char_out   = char_out_reg;
  assign frame_err  = frame_err_reg;
  assign overflow   = overflow_reg;
  assign full       = full_w;
  assign count      = ptr_reg;

endmodule

// File: tb/tb_serial_rx_store.sv
// Directed bench for serial_rx_store: table of frames plus hand-written
// glitch, full-buffer, clear and reset sequences, checked against a RAM log.
module tb_serial_rx_store;

  localparam int CPB = 16;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        serialIn;
  logic        clear;
  logic        ram_write;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        frame_err;
  logic        overflow;
  logic        full;
  logic [7:0]  count;

  serial_rx_store #(.CLKS_PER_BIT(CPB), .CW(5)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .serialIn   (serialIn),
    .clear      (clear),
    .ram_write  (ram_write),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .char_valid (char_valid),
    .char_out   (char_out),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .full       (full),
    .count      (count)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_bad_valid = 0;
  logic [15:0] mem [256];
  logic [7:0]  wa_q [$];
  logic [15:0] wd_q [$];
  int          wc_q [$];

  // Observe the write port and pulses on the falling edge
  always @(negedge sysclk) begin
    cyc++;
    if (ram_write === 1'b1) begin
      mem[ram_addr] = ram_data;
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_data);
      wc_q.push_back(cyc);
    end
    if (char_valid === 1'b1) begin
      n_valid++;
      if (!(ram_write === 1'b1 && ram_data[15] === 1'b1 && ram_data[7:0] === char_out)) n_bad_valid++;
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  typedef struct {
    logic [7:0] ch;
    logic       stop_ok;
    int         exp_addr;
    int         exp_count;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic log_reset();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic stop_lvl, input int stop_len);
    serialIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      serialIn = ch[i];
      tick(CPB);
    end
    serialIn = stop_lvl;
    tick(stop_len);
    serialIn = 1'b1;
    tick(CPB / 2);
  endtask

  task automatic check_store(input string name, input logic [7:0] ch, input int addr, input int cnt);
    chk({name, "_nwr"}, wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk({name, "_addr0"}, wa_q[0], addr);
      chk({name, "_data0"}, wd_q[0], {8'h80, ch});
      chk({name, "_addr1"}, wa_q[1], addr + 1);
      chk({name, "_data1"}, wd_q[1], 16'h0000);
      chk({name, "_adjacent"}, wc_q[1] - wc_q[0], 1);
    end
    chk({name, "_count"}, count, cnt);
    chk({name, "_char_out"}, char_out, ch);
  endtask

  initial begin
    int v0, f0;
    logic [7:0] ch_i;

    vecs[0] = '{ch: 8'h41, stop_ok: 1'b1, exp_addr: 0, exp_count: 1, exp_ferr: 0};
    vecs[1] = '{ch: 8'h33, stop_ok: 1'b0, exp_addr: 0, exp_count: 1, exp_ferr: 1};
    vecs[2] = '{ch: 8'h34, stop_ok: 1'b1, exp_addr: 1, exp_count: 2, exp_ferr: 0};
    vecs[3] = '{ch: 8'h00, stop_ok: 1'b1, exp_addr: 2, exp_count: 3, exp_ferr: 0};
    vecs[4] = '{ch: 8'hFF, stop_ok: 1'b1, exp_addr: 3, exp_count: 4, exp_ferr: 0};
    vecs[5] = '{ch: 8'hA5, stop_ok: 1'b1, exp_addr: 4, exp_count: 5, exp_ferr: 0};

    for (int a = 0; a < 256; a++) mem[a] = 16'hDEAD;

    reset = 1'b1;
    serialIn = 1'b1;
    clear = 1'b0;
    tick(3);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    tick(2);
    $display("reset done count=%0d", count);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      log_reset();
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(vecs[v].ch, vecs[v].stop_ok, vecs[v].stop_ok ? CPB : 2 * CPB);
      if (vecs[v].stop_ok) check_store("vec", vecs[v].ch, vecs[v].exp_addr, vecs[v].exp_count);
      else chk("vec_nowrite", wa_q.size(), 0);
      chk("vec_count", count, vecs[v].exp_count);
      chk("vec_ferr", n_ferr - f0, vecs[v].exp_ferr);
      chk("vec_valid", n_valid - v0, vecs[v].stop_ok ? 1 : 0);
      $display("frame ch=%02h stop_ok=%0d writes=%0d count=%0d", vecs[v].ch, vecs[v].stop_ok, wa_q.size(), count);
    end

    // Glitch: a short low pulse must not start a frame
    log_reset();
    f0 = n_ferr;
    serialIn = 1'b0;
    tick(4);
    serialIn = 1'b1;
    tick(3 * CPB);
    chk("glitch_nowrite", wa_q.size(), 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    chk("glitch_count", count, 5);
    $display("glitch writes=%0d count=%0d", wa_q.size(), count);
    log_reset();
    send_frame(8'h5A, 1'b1, CPB);
    check_store("after_glitch", 8'h5A, 5, 6);
    $display("frame ch=5a writes=%0d count=%0d", wa_q.size(), count);

    // Idle clear, then fill the buffer
    log_reset();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(4);
    chk("idle_clr_nwr", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("idle_clr_addr", wa_q[0], 0);
      chk("idle_clr_data", wd_q[0], 0);
    end
    chk("idle_clr_count", count, 0);
    $display("clear writes=%0d count=%0d", wa_q.size(), count);

    for (int i = 0; i < 255; i++) begin
      ch_i = i[7:0];
      log_reset();
      send_frame(ch_i, 1'b1, CPB);
      check_store("fill", ch_i, i, i + 1);
      if (i == 253) chk("fill_not_full", full, 0);
      $display("fill ch=%02h writes=%0d count=%0d full=%0d", ch_i, wa_q.size(), count, full);
    end
    chk("full_flag", full, 1);
    chk("full_count", count, 255);
    chk("full_no_ovf_yet", overflow, 0);
    chk("full_mem255", mem[255], 16'h0000);
    chk("full_mem0", mem[0], 16'h8000);
    chk("full_mem254", mem[254], 16'h80FE);

    log_reset();
    v0 = n_valid;
    send_frame(8'hEE, 1'b1, CPB);
    chk("ovf_nowrite", wa_q.size(), 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_valid", n_valid - v0, 0);
    chk("ovf_mem255", mem[255], 16'h0000);
    chk("ovf_count", count, 255);
    $display("drop ch=ee writes=%0d overflow=%0d", wa_q.size(), overflow);

    // Clear in the middle of DATA; 0xF0 keeps the line high after bit 3
    log_reset();
    v0 = n_valid;
    ch_i = 8'hF0;
    serialIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      serialIn = ch_i[i];
      tick(CPB);
    end
    serialIn = ch_i[3];
    tick(CPB / 2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(CPB / 2 - 1);
    for (int i = 4; i < 8; i++) begin
      serialIn = ch_i[i];
      tick(CPB);
    end
    serialIn = 1'b1;
    tick(2 * CPB);
    chk("midclr_nwr", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("midclr_addr", wa_q[0], 0);
      chk("midclr_data", wd_q[0], 0);
    end
    chk("midclr_count", count, 0);
    chk("midclr_ovf", overflow, 0);
    chk("midclr_full", full, 0);
    chk("midclr_valid", n_valid - v0, 0);
    $display("midclear writes=%0d count=%0d overflow=%0d", wa_q.size(), count, overflow);
    log_reset();
    send_frame(8'h61, 1'b1, CPB);
    check_store("after_clr", 8'h61, 0, 1);
    $display("frame ch=61 writes=%0d count=%0d", wa_q.size(), count);

    // Reset while the stop bit is being timed
    log_reset();
    v0 = n_valid;
    ch_i = 8'h3C;
    serialIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      serialIn = ch_i[i];
      tick(CPB);
    end
    serialIn = 1'b1;
    tick(CPB / 4);
    reset = 1'b1;
    tick(1);
    chk("midrst_ram_write", ram_write, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_ram_data", ram_data, 0);
    chk("midrst_char_valid", char_valid, 0);
    chk("midrst_char_out", char_out, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_count", count, 0);
    reset = 1'b0;
    tick(2 * CPB);
    chk("midrst_nowrite", wa_q.size(), 0);
    chk("midrst_valid", n_valid - v0, 0);
    chk("midrst_count_after", count, 0);
    $display("midreset writes=%0d count=%0d", wa_q.size(), count);

    chk("valid_alignment", n_bad_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
